// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared LEGv8 datapath widths, XZR index and register-file typedefs
package wb_regfile_pkg;
  localparam int DATA_W = 64;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;
  typedef logic [DATA_W-1:0] dword_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB inputs, ID read ports, forwarding and debug outputs of the write-back regfile
interface wb_regfile_if;
  import wb_regfile_pkg::*;
  dword_t Read_data;
  dword_t Alu_result;
  reg_idx_t Write_reg;
  logic RegWrite;
  logic MemtoReg;
  reg_idx_t read_reg1;
  reg_idx_t read_reg2;
  dword_t read_data1;
  dword_t read_data2;
  dword_t wb_data;
  logic wb_commit;
  reg_idx_t dbg_reg;
  dword_t dbg_data;
  cnt_t commit_cnt;
  modport master (
    output Read_data, Alu_result, Write_reg, RegWrite, MemtoReg, read_reg1, read_reg2, dbg_reg,
    input read_data1, read_data2, wb_data, wb_commit, dbg_data, commit_cnt
  );
  modport slave (
    input Read_data, Alu_result, Write_reg, RegWrite, MemtoReg, read_reg1, read_reg2, dbg_reg,
    output read_data1, read_data2, wb_data, wb_commit, dbg_data, commit_cnt
  );
endinterface

// File: rtl/wb_regfile_wb_mux.sv
// wb_mux: write-back select, load data when mem_to_reg else ALU result
module wb_mux
  import wb_regfile_pkg::*;
(
  input  logic   mem_to_reg,
  input  dword_t rd_data,
  input  dword_t alu_data,
  output dword_t y
);
  assign y = mem_to_reg ? rd_data : alu_data;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: LEGv8 write-back stage with X0..X30 storage, XZR, write-through read ports and commit counter
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input logic   clock,
  input logic   reset,
  wb_regfile_if.slave bus
);
  dword_t regs_q [NUM_REGS-1];
  dword_t regs_d [NUM_REGS-1];
  cnt_t commit_cnt_q, commit_cnt_d;
  dword_t wb_data;
  logic wb_commit;
  wb_mux u_wb_mux (
    .mem_to_reg(bus.MemtoReg),
    .rd_data   (bus.Read_data),
    .alu_data  (bus.Alu_result),
    .y         (wb_data)
  );
  assign wb_commit = bus.RegWrite & (bus.Write_reg != ZERO_REG) & ~reset;
  always_comb begin
    regs_d = regs_q;
    commit_cnt_d = commit_cnt_q + cnt_t'(wb_commit);
    if (wb_commit) regs_d[bus.Write_reg] = wb_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q <= '{default: '0};
      commit_cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end
  always_comb begin
    bus.read_data1 = (bus.read_reg1 == ZERO_REG) ? '0 :
                     (BYPASS && wb_commit && bus.Write_reg == bus.read_reg1) ? wb_data :
                     regs_q[bus.read_reg1];
    bus.read_data2 = (bus.read_reg2 == ZERO_REG) ? '0 :
                     (BYPASS && wb_commit && bus.Write_reg == bus.read_reg2) ? wb_data :
                     regs_q[bus.read_reg2];
    bus.dbg_data = (bus.dbg_reg == ZERO_REG) ? '0 : regs_q[bus.dbg_reg];
  end
  assign bus.wb_data = wb_data;
  assign bus.wb_commit = wb_commit;
  assign bus.commit_cnt = commit_cnt_q;
endmodule
